// File: rtl/ddmtd_lock_ctrl_if.sv
// Control/status bundle for ddmtd_lock_ctrl: run request, phase-error stream
// and lock-state outputs. The master drives the request side, the slave reports status.
interface ddmtd_lock_ctrl_if #(
  parameter int unsigned ERR_W = 16
);
  logic                    ena;
  logic                    start;
  logic                    phase_valid;
  logic signed [ERR_W-1:0] phase_err;
  logic                    sel_close;
  logic                    gain_fast;
  logic                    lf_hold;
  logic                    locked;
  logic                    lock_lost;
  logic                    fault;
  logic [2:0]              state;

  modport master (
    output ena, start, phase_valid, phase_err,
    input  sel_close, gain_fast, lf_hold, locked, lock_lost, fault, state
  );

  modport slave (
    input  ena, start, phase_valid, phase_err,
    output sel_close, gain_fast, lf_hold, locked, lock_lost, fault, state
  );
endinterface

// File: rtl/ddmtd_lock_ctrl.sv
// DDMTD lock sequencer: IDLE -> SETTLE -> ACQ -> TRACK -> LOCKED with registered outputs.
// Define DDMTD_ACQ_TIMEOUT_EN to enable the ACQ/TRACK watchdog and the FAULT state.
module ddmtd_lock_ctrl #(
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned SETTLE_CYC  = 256,
  parameter int unsigned ACQ_THR     = 2048,
  parameter int unsigned ACQ_CNT     = 8,
  parameter int unsigned LOCK_THR    = 256,
  parameter int unsigned LOCK_CNT    = 32,
  parameter int unsigned UNLOCK_CNT  = 4,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input logic              clk,
  input logic              rst_n,
  ddmtd_lock_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ACQ    = 3'd2,
    S_TRACK  = 3'd3,
    S_LOCKED = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int unsigned CNT_MAX = (ACQ_CNT > LOCK_CNT)
                                    ? ((ACQ_CNT > UNLOCK_CNT) ? ACQ_CNT : UNLOCK_CNT)
                                    : ((LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SET_W   = $clog2(SETTLE_CYC + 1);

  if (SETTLE_CYC == 0 || ACQ_CNT == 0 || LOCK_CNT == 0 || UNLOCK_CNT == 0 ||
      TIMEOUT_CYC == 0 || LOCK_THR > ACQ_THR) begin : g_bad_cfg
    $error("ddmtd_lock_ctrl: invalid parameter set");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               sel_q, gain_q, hold_q, locked_q, lost_q;
  logic               sel_d, gain_d, hold_d, locked_d, lost_d;

  logic signed [ERR_W-1:0] perr;
  logic [ERR_W-1:0]        err_abs;
  logic                    acq_ok, lock_ok;

  // Most-negative input has no positive twin; saturate it to the largest magnitude.
  assign perr = bus.phase_err;
  always_comb begin
    if (perr[ERR_W-1] && (perr[ERR_W-2:0] == '0)) err_abs = {1'b0, {(ERR_W-1){1'b1}}};
    else if (perr[ERR_W-1])                          err_abs = -perr;
    else                                             err_abs = perr;
  end
  assign acq_ok  = (32'(err_abs) <= ACQ_THR);
  assign lock_ok = (32'(err_abs) <= LOCK_THR);

`ifdef DDMTD_ACQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_run, wd_expired;
  assign wd_run     = (state_q == S_ACQ) || (state_q == S_TRACK);
  assign wd_expired = wd_run && (wd_q == WD_W'(TIMEOUT_CYC - 1));
`endif

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = '0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_SETTLE;
      S_SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYC - 1)) state_d = S_ACQ;
        else                                  set_d   = set_q + SET_W'(1);
      end
      S_ACQ: if (bus.phase_valid) begin
        if (!acq_ok)                             cnt_d   = '0;
        else if (cnt_q == CNT_W'(ACQ_CNT - 1))   state_d = S_TRACK;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_TRACK: if (bus.phase_valid) begin
        if (!acq_ok)                             state_d = S_ACQ;
        else if (!lock_ok)                       cnt_d   = '0;
        else if (cnt_q == CNT_W'(LOCK_CNT - 1))  state_d = S_LOCKED;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_LOCKED: if (bus.phase_valid) begin
        if (lock_ok)                             cnt_d   = '0;
        else if (cnt_q == CNT_W'(UNLOCK_CNT - 1)) state_d = S_ACQ;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
`ifdef DDMTD_ACQ_TIMEOUT_EN
    if (wd_expired) state_d = S_FAULT;
`endif
    if (!bus.start) state_d = S_IDLE;
    if (state_d != state_q) begin
      cnt_d = '0;
      set_d = '0;
    end
  end

`ifdef DDMTD_ACQ_TIMEOUT_EN
  always_comb begin
    wd_d = '0;
    if (wd_run && ((state_d == S_ACQ) || (state_d == S_TRACK))) wd_d = wd_q + WD_W'(1);
  end
`endif

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    sel_d    = 1'b0;
    gain_d   = 1'b0;
    hold_d   = 1'b0;
    locked_d = 1'b0;
    case (state_d)
      S_SETTLE: begin sel_d = 1'b1; gain_d = 1'b1; hold_d = 1'b1; end
      S_ACQ:    begin sel_d = 1'b1; gain_d = 1'b1; end
      S_TRACK:  sel_d = 1'b1;
      S_LOCKED: begin sel_d = 1'b1; locked_d = 1'b1; end
      default:  ;
    endcase
    lost_d = (state_q == S_LOCKED) && (state_d == S_ACQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      set_q    <= '0;
      sel_q    <= 1'b0;
      gain_q   <= 1'b0;
      hold_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else if (bus.ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      sel_q    <= sel_d;
      gain_q   <= gain_d;
      hold_q   <= hold_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end else begin
      lost_q   <= 1'b0;
    end
  end

`ifdef DDMTD_ACQ_TIMEOUT_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else if (bus.ena) begin
      wd_q    <= wd_d;
      fault_q <= (state_d == S_FAULT);
    end
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.state     = state_q;
  assign bus.sel_close = sel_q;
  assign bus.gain_fast = gain_q;
  assign bus.lf_hold   = hold_q;
  assign bus.locked    = locked_q;
  assign bus.lock_lost = lost_q;

endmodule
